// File: rtl/pc_branch_unit.sv
// rtl/pc_branch_unit.sv - program counter, branch resolution and return-address stack
//
// Purpose: owns the PC and a LIFO return stack; resolves SEQ/JMP/BRT/BRF/CALL/RET/HALT
// for the instruction currently addressed by o_pc_out.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_en         advance enable (0 = stall, no state change)
//   i_op         sequencing op for the instruction at o_pc_out
//   i_flag_in    registered ALU flag, used as presented this cycle
//   i_target     branch/jump/call destination
//   o_pc_out     current PC (registered)
//   o_taken      combinational: current op redirects the PC this cycle
//   o_halted     registered: unit is in HALT
//   o_stack_err  registered, sticky: return-stack overflow/underflow seen
//   o_sp_out     current stack occupancy (registered)

module pc_branch_unit #(
  parameter int              PC_W        = 8,
  parameter int              STACK_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC    = '0
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_en,
  input  logic [2:0]                     i_op,
  input  logic                           i_flag_in,
  input  logic [PC_W-1:0]                i_target,
  output logic [PC_W-1:0]                o_pc_out,
  output logic                           o_taken,
  output logic                           o_halted,
  output logic                           o_stack_err,
  output logic [$clog2(STACK_DEPTH):0]   o_sp_out
);

  localparam int AW   = $clog2(STACK_DEPTH);
  localparam int SP_W = AW + 1;

  localparam logic [2:0] OP_SEQ  = 3'b000;
  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_BRT  = 3'b010;
  localparam logic [2:0] OP_BRF  = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b110;

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   w_pc_nxt;
  logic [PC_W-1:0]   w_pc_inc;
  logic [SP_W-1:0]   r_sp;
  logic [SP_W-1:0]   w_sp_nxt;
  logic              r_err;
  logic              w_err_nxt;
  logic              w_taken;
  logic              w_push;
  logic              w_active;
  logic              w_full;
  logic              w_empty;
  logic [AW-1:0]     w_top_idx;
  logic [PC_W-1:0]   r_stack [STACK_DEPTH];

  // Only RUN with enable evaluates an op; HALT and stalls freeze everything.
  assign w_active  = i_en && (r_state == S_RUN);
  assign w_full    = (r_sp == SP_W'(STACK_DEPTH));
  assign w_empty   = (r_sp == '0);
  assign w_pc_inc  = r_pc + PC_W'(1);
  assign w_top_idx = AW'(r_sp - SP_W'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_active && (i_op == OP_HALT)) begin
      w_state_nxt = S_HALT;
    end
  end

  always_comb begin
    w_taken   = 1'b0;
    w_pc_nxt  = r_pc;
    w_sp_nxt  = r_sp;
    w_err_nxt = r_err;
    w_push    = 1'b0;
    if (w_active) begin
      case (i_op)
        OP_JMP: begin
          w_taken  = 1'b1;
          w_pc_nxt = i_target;
        end
        OP_BRT: begin
          w_taken  = i_flag_in;
          w_pc_nxt = i_flag_in ? i_target : w_pc_inc;
        end
        OP_BRF: begin
          w_taken  = !i_flag_in;
          w_pc_nxt = i_flag_in ? w_pc_inc : i_target;
        end
        OP_CALL: begin
          if (!w_full) begin
            w_taken  = 1'b1;
            w_push   = 1'b1;
            w_sp_nxt = r_sp + SP_W'(1);
            w_pc_nxt = i_target;
          end else begin
            w_pc_nxt  = w_pc_inc;
            w_err_nxt = 1'b1;
          end
        end
        OP_RET: begin
          if (!w_empty) begin
            w_taken  = 1'b1;
            w_sp_nxt = r_sp - SP_W'(1);
            w_pc_nxt = r_stack[w_top_idx];
          end else begin
            w_pc_nxt  = w_pc_inc;
            w_err_nxt = 1'b1;
          end
        end
        OP_HALT: begin
          w_pc_nxt = r_pc;
        end
        default: begin
          // SEQ and the reserved encoding both fall through
          w_pc_nxt = w_pc_inc;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc  <= RESET_PC;
      r_sp  <= '0;
      r_err <= 1'b0;
    end else begin
      r_pc  <= w_pc_nxt;
      r_sp  <= w_sp_nxt;
      r_err <= w_err_nxt;
    end
  end

  // Stack contents need no reset; occupancy alone decides validity.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_stack[r_sp[AW-1:0]] <= w_pc_inc;
    end
  end

  assign o_pc_out    = r_pc;
  assign o_taken     = w_taken;
  assign o_halted    = (r_state == S_HALT);
  assign o_stack_err = r_err;
  assign o_sp_out    = r_sp;

  logic w_unused;
  assign w_unused = (OP_SEQ == 3'b000);

endmodule

// File: tb/tb_pc_branch_unit.sv
// tb/tb_pc_branch_unit.sv - scoreboard bench for pc_branch_unit with directed vectors

module tb_pc_branch_unit;

  localparam logic [2:0] SEQ  = 3'b000;
  localparam logic [2:0] JMP  = 3'b001;
  localparam logic [2:0] BRT  = 3'b010;
  localparam logic [2:0] BRF  = 3'b011;
  localparam logic [2:0] CALL = 3'b100;
  localparam logic [2:0] RET  = 3'b101;
  localparam logic [2:0] HALT = 3'b110;
  localparam logic [2:0] RSVD = 3'b111;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] op;
  logic       flag;
  logic [7:0] tgt;
  logic [7:0] pc_out;
  logic       taken;
  logic       halted;
  logic       stack_err;
  logic [2:0] sp_out;

  typedef struct {
    logic       taken;
    logic [7:0] pc;
    logic [2:0] sp;
    logic       halted;
    logic       err;
    logic       now;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  pc_branch_unit #(.PC_W(8), .STACK_DEPTH(4), .RESET_PC(8'h00)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_en        (en),
    .i_op        (op),
    .i_flag_in   (flag),
    .i_target    (tgt),
    .o_pc_out    (pc_out),
    .o_taken     (taken),
    .o_halted    (halted),
    .o_stack_err (stack_err),
    .o_sp_out    (sp_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int idx, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL item %0d %s: got %0h expected %0h", idx, nm, act, exp);
    end
  endtask

  task automatic chk_state(input int idx, input string tag, input exp_t e);
    chk(idx, {tag, " pc"},     32'(pc_out),    32'(e.pc));
    chk(idx, {tag, " sp"},     32'(sp_out),    32'(e.sp));
    chk(idx, {tag, " halted"}, 32'(halted),    32'(e.halted));
    chk(idx, {tag, " err"},    32'(stack_err), 32'(e.err));
  endtask

  // expected values are the state after the edge that consumes this op
  task automatic step(input logic e, input logic [2:0] o, input logic f, input logic [7:0] t,
                      input logic et, input logic [7:0] epc, input logic [2:0] esp,
                      input logic eh, input logic ee);
    exp_t x;
    @(negedge clk);
    rst_n = 1'b1; en = e; op = o; flag = f; tgt = t;
    x = '{et, epc, esp, eh, ee, 1'b0};
    sb.push_back(x);
  endtask

  task automatic reset_pulse();
    exp_t x;
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; op = SEQ; flag = 1'b0; tgt = 8'h00;
    x = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1};
    sb.push_back(x);
  endtask

  // monitor: taken mid-cycle, registered state just after the edge
  initial begin : monitor
    int   idx;
    exp_t cur;
    idx = 0;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() > 0) begin
        cur = sb[0];
        chk(idx, "taken", 32'(taken), 32'(cur.taken));
        if (cur.now) chk_state(idx, "async", cur);
        @(posedge clk);
        #1;
        chk_state(idx, "post", cur);
        sb.delete(0);
        idx++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst_n = 1'b0; en = 1'b0; op = SEQ; flag = 1'b0; tgt = 8'h00;

    // reset / sequence
    reset_pulse();
    step(1, SEQ, 0, 8'h00, 0, 8'h01, 3'd0, 0, 0);
    step(1, SEQ, 0, 8'h00, 0, 8'h02, 3'd0, 0, 0);
    reset_pulse();
    for (int i = 1; i <= 5; i++) step(1, SEQ, 0, 8'h00, 0, 8'(i), 3'd0, 0, 0);

    // conditional branches
    step(1, JMP, 0, 8'h03, 1, 8'h03, 3'd0, 0, 0);
    step(1, BRT, 1, 8'h40, 1, 8'h40, 3'd0, 0, 0);
    step(1, BRF, 1, 8'h10, 0, 8'h41, 3'd0, 0, 0);
    step(1, BRF, 0, 8'h10, 1, 8'h10, 3'd0, 0, 0);
    step(1, BRT, 0, 8'h70, 0, 8'h11, 3'd0, 0, 0);

    // call/return nesting
    step(1, JMP,  0, 8'h05, 1, 8'h05, 3'd0, 0, 0);
    step(1, CALL, 0, 8'h20, 1, 8'h20, 3'd1, 0, 0);
    step(1, CALL, 0, 8'h30, 1, 8'h30, 3'd2, 0, 0);
    step(1, RET,  0, 8'h00, 1, 8'h21, 3'd1, 0, 0);
    step(1, RET,  0, 8'h00, 1, 8'h06, 3'd0, 0, 0);

    // overflow then unwind in LIFO order
    step(1, CALL, 0, 8'h50, 1, 8'h50, 3'd1, 0, 0);
    step(1, CALL, 0, 8'h60, 1, 8'h60, 3'd2, 0, 0);
    step(1, CALL, 0, 8'h70, 1, 8'h70, 3'd3, 0, 0);
    step(1, CALL, 0, 8'h80, 1, 8'h80, 3'd4, 0, 0);
    step(1, CALL, 0, 8'h90, 0, 8'h81, 3'd4, 0, 1);
    step(1, RET,  0, 8'h00, 1, 8'h71, 3'd3, 0, 1);
    step(1, RET,  0, 8'h00, 1, 8'h61, 3'd2, 0, 1);
    step(1, RET,  0, 8'h00, 1, 8'h51, 3'd1, 0, 1);
    step(1, RET,  0, 8'h00, 1, 8'h07, 3'd0, 0, 1);

    // underflow, sticky error, reserved op
    reset_pulse();
    step(1, RET,  0, 8'h00, 0, 8'h01, 3'd0, 0, 1);
    step(1, SEQ,  0, 8'h00, 0, 8'h02, 3'd0, 0, 1);
    step(1, RSVD, 0, 8'h77, 0, 8'h03, 3'd0, 0, 1);
    reset_pulse();

    // stall and wrap
    step(1, JMP, 0, 8'hFF, 1, 8'hFF, 3'd0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, SEQ, 0, 8'h00, 0, 8'hFF, 3'd0, 0, 0);
    step(1, SEQ,  0, 8'h00, 0, 8'h00, 3'd0, 0, 0);
    step(0, JMP,  0, 8'h33, 0, 8'h00, 3'd0, 0, 0);
    step(0, CALL, 0, 8'h44, 0, 8'h00, 3'd0, 0, 0);

    // halt
    step(1, JMP,  0, 8'h11, 1, 8'h11, 3'd1 - 3'd1, 0, 0);
    step(1, CALL, 0, 8'h12, 1, 8'h12, 3'd1, 0, 0);
    step(1, HALT, 0, 8'h00, 0, 8'h12, 3'd1, 1, 0);
    step(1, JMP,  0, 8'h50, 0, 8'h12, 3'd1, 1, 0);
    step(1, CALL, 0, 8'h60, 0, 8'h12, 3'd1, 1, 0);
    step(1, RET,  0, 8'h00, 0, 8'h12, 3'd1, 1, 0);
    reset_pulse();
    step(1, SEQ,  0, 8'h00, 0, 8'h01, 3'd0, 0, 0);

    // drain the scoreboard with a bounded wait
    begin
      int budget;
      budget = 0;
      while (sb.size() > 0 && budget < 20) begin
        @(posedge clk);
        budget++;
      end
      #3;
      n_checks++;
      if (sb.size() != 0) begin
        n_errors++;
        $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
